rtc_match_counter: RTL and testbench
====================================

# rtc_match_counter

Parametrised real-time counter for the RTC subsystem. It replaces the fixed 32-bit, externally-clocked counter with a single-clock design:
- an on-chip prescaler produces the count tick;
- width and reset value are parameters;
- software can load the count;
- a match comparator raises a sticky, maskable alarm interrupt, and a sticky flag records wrap-around.

It sits between the APB register block, which drives the load/match/control inputs, and the interrupt combiner, which consumes RTCINTR.

## Interface
Parameters:
- CNT_W, 32, counter width (2..64)
- DIV_W, 16, prescaler divisor width (1..32)
- RST_VAL, 1, Count value at reset (CNT_W bits)

Ports:
- RTCCLK  in  1  RTC clock; all state updates on rising edge
- RTCRST  in  1  reset, asynchronous, active-high
- EN  in  1  count enable; low freezes prescaler and Count
- DIVISOR  in  DIV_W  tick period minus one (0 = tick every cycle)
- LOAD  in  1  single-cycle load strobe
- LOADVAL  in  CNT_W  value written to Count on LOAD
- TESTCOUNT  in  1  test mode: Count follows RTCTCOUNT
- RTCTCOUNT  in  CNT_W  test count value
- MATCHVAL  in  CNT_W  alarm compare value
- INTMASK  in  1  1 = alarm interrupt enabled
- INTCLR  in  1  clears RAWINT
- WRAPCLR  in  1  clears WRAP
- Count  out  CNT_W  current count, registered
- TICK  out  1  registered one-cycle pulse, high in the cycle an incremented Count first appears
- RAWINT  out  1  sticky match status, registered
- RTCINTR  out  1  RAWINT & INTMASK, combinational
- WRAP  out  1  sticky overflow status, registered

## Operation
- **Reset values.** Count=RST_VAL, prescaler PreCnt=0, TICK=0, RAWINT=0, WRAP=0.
- **Prescaler.** Applies when EN=1, TESTCOUNT=0 and LOAD=0:
  - if PreCnt >= DIVISOR: PreCnt<=0 and an increment event occurs;
  - otherwise PreCnt<=PreCnt+1.
  - The >= compare means lowering DIVISOR mid-period ends the current period on the next cycle.
- **Count update priority:** TESTCOUNT > LOAD > increment event > hold.
  - TESTCOUNT=1: Count<=RTCTCOUNT every cycle, regardless of EN; PreCnt held.
  - LOAD=1 (TESTCOUNT=0): Count<=LOADVAL, PreCnt<=0, regardless of EN.
  - Increment: Count<=Count+1, modulo 2^CNT_W. TICK<=1 in the same edge; otherwise TICK<=0.
- **Wrap.** WRAP is set when an increment takes Count from all-ones to 0. LOAD or TESTCOUNT writing 0 does not set WRAP.
- **Match.** RAWINT is set on any edge where Count is written (increment, LOAD or TESTCOUNT) with a value equal to MATCHVAL.
  - Holding at MATCHVAL does not re-set RAWINT after a clear.
  - Changing MATCHVAL to equal the current Count does not set RAWINT.
- **Clears.** INTCLR clears RAWINT; WRAPCLR clears WRAP. If set and clear occur in the same cycle, set wins.
- **EN=0.** PreCnt, Count and the sticky flags hold; clears still act.

## Timing
- Increment latency: with EN continuously high from PreCnt=0, Count changes DIVISOR+1 cycles after EN rises. Period between TICKs is DIVISOR+1 cycles.
- Load/test latency: LOAD or TESTCOUNT sampled at edge N, so Count is valid after edge N; RAWINT for a matching load also rises after edge N.
- RTCINTR follows INTMASK combinationally, with zero cycles of latency.
- Reset mid-operation: all registers return to their reset values asynchronously when RTCRST rises. Release is synchronised externally; the first increment occurs DIVISOR+1 enabled cycles after release.
- No multicycle paths. The adder and comparator must close timing at CNT_W=64 in one cycle.

## Structure
- Package rtc_pkg holds:
  - default constants RTC_CNT_W=32, RTC_DIV_W=16, RTC_RST_VAL=1;
  - a typedef for the update-source encoding (NONE, INC, LOAD, TEST), used for the priority mux and by the bench monitor.
- Sub-module rtc_prescaler (DIV_W parameter):
  - inputs: RTCCLK, RTCRST, advance enable, sync clear, DIVISOR;
  - output: increment event.
- The top level holds the Count register, priority mux, match/wrap logic and sticky flags.

## Test plan
- **Divide.** DIVISOR=3, EN=1 from reset (CNT_W=32, RST_VAL=1) → TICK every 4 cycles; Count 1→2→3 at cycles 4, 8.
- **Wrap.** LOAD LOADVAL=32'hFFFFFFFE, DIVISOR=0 → Count FFFFFFFF then 0; WRAP=1 from the 0 edge; WRAPCLR clears it next edge.
- **Match and mask.** Proceed as follows:
  - MATCHVAL=10, INTMASK=0, count up from 8 → RAWINT=1 when Count=10, RTCINTR=0;
  - set INTMASK=1 → RTCINTR=1 in the same cycle;
  - INTCLR → both 0 while Count holds at 10 with EN=0.
- **Priority.** Same cycle TESTCOUNT=1 (RTCTCOUNT=5), LOAD=1 (LOADVAL=9) and a due increment → Count=5; PreCnt unchanged. Then TESTCOUNT=0, LOAD=1 → Count=9, PreCnt=0.
- **Set beats clear.** INTCLR asserted on the edge Count increments to MATCHVAL → RAWINT=1.
- **Async reset.** Assert RTCRST mid-period with Count=0x1234 and RAWINT=1 → Count=1 and flags 0 immediately; first TICK DIVISOR+1 cycles after release.

Source files
------------

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared constants and types for the RTC match counter slice.
//               Holds default widths/reset value and the Count update-source
//               encoding used by the priority mux.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int          RTC_CNT_W   = 32;
    localparam int          RTC_DIV_W   = 16;
    localparam logic [63:0] RTC_RST_VAL = 64'd1;

    // Which source writes Count on a given edge, highest priority last.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_INC  = 2'd1,
        SRC_LOAD = 2'd2,
        SRC_TEST = 2'd3
    } upd_src_e;

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/rtc_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : rtc_prescaler
// Description : Programmable tick prescaler. Counts enabled cycles and
//               flags an increment event every DIVISOR+1 advances.
// Ports       : RTCCLK   - clock, rising edge
//               RTCRST   - asynchronous active-high reset
//               advance  - step the prescaler this cycle
//               clear    - synchronous clear (wins over advance)
//               DIVISOR  - period minus one
//               inc      - increment event (combinational, qualified by advance)
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int DIV_W = RTC_DIV_W
) (
    input  logic             RTCCLK,
    input  logic             RTCRST,
    input  logic             advance,
    input  logic             clear,
    input  logic [DIV_W-1:0] DIVISOR,
    output logic             inc
);

    logic [DIV_W-1:0] r_precnt;
    logic             w_due;

    // Greater-or-equal so a lowered DIVISOR terminates the current period
    // on the next advance instead of running round the full counter range.
    assign w_due = (r_precnt >= DIVISOR);
    assign inc   = advance & w_due;

    always_ff @(posedge RTCCLK or posedge RTCRST) begin
        if (RTCRST) begin
            r_precnt <= '0;
        end else if (clear) begin
            r_precnt <= '0;
        end else if (advance) begin
            if (w_due) begin
                r_precnt <= '0;
            end else begin
                r_precnt <= r_precnt + DIV_W'(1);
            end
        end
    end

endmodule : rtc_prescaler
`default_nettype wire

// File: rtl/rtc_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_match_counter
// Description : Parametrised single-clock real-time counter with prescaler,
//               software load, test-mode override, sticky maskable match
//               interrupt and sticky wrap flag.
// Ports       : RTCCLK, RTCRST            - clock / async active-high reset
//               EN, DIVISOR               - count enable, tick period - 1
//               LOAD, LOADVAL             - load strobe and value
//               TESTCOUNT, RTCTCOUNT      - test override and value
//               MATCHVAL, INTMASK         - alarm compare value, irq enable
//               INTCLR, WRAPCLR           - sticky flag clears
//               Count, TICK               - count and increment pulse
//               RAWINT, RTCINTR, WRAP     - match status, masked irq, wrap
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_match_counter
    import rtc_pkg::*;
#(
    parameter int               CNT_W   = RTC_CNT_W,
    parameter int               DIV_W   = RTC_DIV_W,
    parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(RTC_RST_VAL)
) (
    input  logic             RTCCLK,
    input  logic             RTCRST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIVISOR,
    input  logic             LOAD,
    input  logic [CNT_W-1:0] LOADVAL,
    input  logic             TESTCOUNT,
    input  logic [CNT_W-1:0] RTCTCOUNT,
    input  logic [CNT_W-1:0] MATCHVAL,
    input  logic             INTMASK,
    input  logic             INTCLR,
    input  logic             WRAPCLR,
    output logic [CNT_W-1:0] Count,
    output logic             TICK,
    output logic             RAWINT,
    output logic             RTCINTR,
    output logic             WRAP
);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_rawint;
    logic             r_wrap;

    logic             w_inc;
    logic             w_pre_adv;
    logic             w_pre_clr;
    upd_src_e         w_src;
    logic [CNT_W-1:0] w_next_count;
    logic             w_match_set;
    logic             w_wrap_set;

    // Test mode freezes the prescaler; a load restarts the period.
    assign w_pre_adv = EN & ~TESTCOUNT & ~LOAD;
    assign w_pre_clr = LOAD & ~TESTCOUNT;

    rtc_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .RTCCLK  (RTCCLK),
        .RTCRST  (RTCRST),
        .advance (w_pre_adv),
        .clear   (w_pre_clr),
        .DIVISOR (DIVISOR),
        .inc     (w_inc)
    );

    always_comb begin
        w_src        = SRC_NONE;
        w_next_count = r_count;
        if (TESTCOUNT) begin
            w_src = SRC_TEST;
        end else if (LOAD) begin
            w_src = SRC_LOAD;
        end else if (w_inc) begin
            w_src = SRC_INC;
        end
        case (w_src)
            SRC_TEST: w_next_count = RTCTCOUNT;
            SRC_LOAD: w_next_count = LOADVAL;
            SRC_INC:  w_next_count = r_count + CNT_W'(1);
            default:  w_next_count = r_count;
        endcase
    end

    // Match only fires on a write to Count, never on a static compare, so
    // a held value or a MATCHVAL change cannot re-arm the alarm.
    assign w_match_set = (w_src != SRC_NONE) && (w_next_count == MATCHVAL);
    assign w_wrap_set  = (w_src == SRC_INC) && (r_count == {CNT_W{1'b1}});

    always_ff @(posedge RTCCLK or posedge RTCRST) begin
        if (RTCRST) begin
            r_count  <= RST_VAL;
            r_tick   <= 1'b0;
            r_rawint <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tick  <= (w_src == SRC_INC);
            // Set takes priority over clear.
            if (w_match_set) begin
                r_rawint <= 1'b1;
            end else if (INTCLR) begin
                r_rawint <= 1'b0;
            end
            if (w_wrap_set) begin
                r_wrap <= 1'b1;
            end else if (WRAPCLR) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign Count   = r_count;
    assign TICK    = r_tick;
    assign RAWINT  = r_rawint;
    assign WRAP    = r_wrap;
    assign RTCINTR = r_rawint & INTMASK;

endmodule : rtc_match_counter
`default_nettype wire

// File: tb/tb_rtc_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_match_counter
// Description : Directed self-checking bench for rtc_match_counter with the
//               default 32-bit count / 16-bit divisor configuration.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rtc_match_counter;

    logic        RTCCLK;
    logic        RTCRST;
    logic        EN;
    logic [15:0] DIVISOR;
    logic        LOAD;
    logic [31:0] LOADVAL;
    logic        TESTCOUNT;
    logic [31:0] RTCTCOUNT;
    logic [31:0] MATCHVAL;
    logic        INTMASK;
    logic        INTCLR;
    logic        WRAPCLR;
    logic [31:0] Count;
    logic        TICK;
    logic        RAWINT;
    logic        RTCINTR;
    logic        WRAP;

    int chk_cnt;
    int pass_cnt;

    rtc_match_counter dut (
        .RTCCLK    (RTCCLK),
        .RTCRST    (RTCRST),
        .EN        (EN),
        .DIVISOR   (DIVISOR),
        .LOAD      (LOAD),
        .LOADVAL   (LOADVAL),
        .TESTCOUNT (TESTCOUNT),
        .RTCTCOUNT (RTCTCOUNT),
        .MATCHVAL  (MATCHVAL),
        .INTMASK   (INTMASK),
        .INTCLR    (INTCLR),
        .WRAPCLR   (WRAPCLR),
        .Count     (Count),
        .TICK      (TICK),
        .RAWINT    (RAWINT),
        .RTCINTR   (RTCINTR),
        .WRAP      (WRAP)
    );

    initial RTCCLK = 1'b0;
    always #5 RTCCLK = ~RTCCLK;

    // Advance one rising edge; return 1ns later so outputs are settled.
    task automatic step();
        @(posedge RTCCLK);
        #1;
    endtask

    task automatic test_reset();
        RTCRST = 1'b1; EN = 1'b1; DIVISOR = 16'd3; LOAD = 1'b0; LOADVAL = '0;
        TESTCOUNT = 1'b0; RTCTCOUNT = '0; MATCHVAL = 32'hDEAD_BEEF;
        INTMASK = 1'b1; INTCLR = 1'b0; WRAPCLR = 1'b0;
        step();
        step();
        chk_cnt++; if (Count !== 32'd1) $display("FAIL reset_count: got %h want %h", Count, 32'd1); else pass_cnt++;
        chk_cnt++; if (TICK !== 1'b0) $display("FAIL reset_tick: got %b want 0", TICK); else pass_cnt++;
        chk_cnt++; if (RAWINT !== 1'b0) $display("FAIL reset_rawint: got %b want 0", RAWINT); else pass_cnt++;
        chk_cnt++; if (WRAP !== 1'b0) $display("FAIL reset_wrap: got %b want 0", WRAP); else pass_cnt++;
        chk_cnt++; if (RTCINTR !== 1'b0) $display("FAIL reset_rtcintr: got %b want 0", RTCINTR); else pass_cnt++;
    endtask

    // DIVISOR=3, EN high through release: Count 1 -> 2 at edge 4, -> 3 at edge 8.
    task automatic test_divide();
        logic [31:0] exp_cnt [1:8];
        logic        exp_tck [1:8];
        exp_cnt = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd3};
        exp_tck = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        RTCRST = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_cnt++; if (Count !== exp_cnt[i]) $display("FAIL divide_count[%0d]: got %h want %h", i, Count, exp_cnt[i]); else pass_cnt++;
            chk_cnt++; if (TICK !== exp_tck[i]) $display("FAIL divide_tick[%0d]: got %b want %b", i, TICK, exp_tck[i]); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        DIVISOR = 16'd0; EN = 1'b1;
        LOAD = 1'b1; LOADVAL = 32'hFFFF_FFFE;
        step();
        LOAD = 1'b0;
        chk_cnt++; if (Count !== 32'hFFFF_FFFE) $display("FAIL wrap_load: got %h want %h", Count, 32'hFFFF_FFFE); else pass_cnt++;
        step();
        chk_cnt++; if (Count !== 32'hFFFF_FFFF) $display("FAIL wrap_allones: got %h want %h", Count, 32'hFFFF_FFFF); else pass_cnt++;
        chk_cnt++; if (WRAP !== 1'b0) $display("FAIL wrap_early: got %b want 0", WRAP); else pass_cnt++;
        step();
        EN = 1'b0;
        chk_cnt++; if (Count !== 32'd0) $display("FAIL wrap_zero: got %h want 0", Count); else pass_cnt++;
        chk_cnt++; if (WRAP !== 1'b1) $display("FAIL wrap_set: got %b want 1", WRAP); else pass_cnt++;
        chk_cnt++; if (TICK !== 1'b1) $display("FAIL wrap_tick: got %b want 1", TICK); else pass_cnt++;
        WRAPCLR = 1'b1;
        step();
        WRAPCLR = 1'b0;
        chk_cnt++; if (WRAP !== 1'b0) $display("FAIL wrap_clear: got %b want 0", WRAP); else pass_cnt++;
        // A load of zero is not a wrap.
        LOAD = 1'b1; LOADVAL = 32'd0;
        step();
        LOAD = 1'b0;
        chk_cnt++; if (WRAP !== 1'b0) $display("FAIL wrap_load_zero: got %b want 0", WRAP); else pass_cnt++;
    endtask

    task automatic test_match_mask();
        EN = 1'b0; DIVISOR = 16'd0; MATCHVAL = 32'd10; INTMASK = 1'b0;
        LOAD = 1'b1; LOADVAL = 32'd8;
        step();
        LOAD = 1'b0; EN = 1'b1;
        chk_cnt++; if (RAWINT !== 1'b0) $display("FAIL match_pre: got %b want 0", RAWINT); else pass_cnt++;
        step();
        chk_cnt++; if (Count !== 32'd9) $display("FAIL match_count9: got %h want 9", Count); else pass_cnt++;
        step();
        EN = 1'b0;
        chk_cnt++; if (Count !== 32'd10) $display("FAIL match_count10: got %h want 10", Count); else pass_cnt++;
        chk_cnt++; if (RAWINT !== 1'b1) $display("FAIL match_rawint: got %b want 1", RAWINT); else pass_cnt++;
        chk_cnt++; if (RTCINTR !== 1'b0) $display("FAIL match_masked: got %b want 0", RTCINTR); else pass_cnt++;
        INTMASK = 1'b1;
        #1;
        chk_cnt++; if (RTCINTR !== 1'b1) $display("FAIL match_unmask: got %b want 1", RTCINTR); else pass_cnt++;
        INTCLR = 1'b1;
        step();
        INTCLR = 1'b0;
        chk_cnt++; if (RAWINT !== 1'b0) $display("FAIL match_clr_raw: got %b want 0", RAWINT); else pass_cnt++;
        chk_cnt++; if (RTCINTR !== 1'b0) $display("FAIL match_clr_intr: got %b want 0", RTCINTR); else pass_cnt++;
        step();
        chk_cnt++; if (RAWINT !== 1'b0) $display("FAIL match_hold: got %b want 0", RAWINT); else pass_cnt++;
        chk_cnt++; if (Count !== 32'd10) $display("FAIL match_hold_count: got %h want 10", Count); else pass_cnt++;
    endtask

    task automatic test_set_beats_clear();
        MATCHVAL = 32'd12; EN = 1'b1;
        step();
        chk_cnt++; if (Count !== 32'd11) $display("FAIL sbc_count11: got %h want 11", Count); else pass_cnt++;
        INTCLR = 1'b1;
        step();
        INTCLR = 1'b0; EN = 1'b0;
        chk_cnt++; if (Count !== 32'd12) $display("FAIL sbc_count12: got %h want 12", Count); else pass_cnt++;
        chk_cnt++; if (RAWINT !== 1'b1) $display("FAIL sbc_rawint: got %b want 1", RAWINT); else pass_cnt++;
        INTCLR = 1'b1;
        step();
        INTCLR = 1'b0;
    endtask

    task automatic test_priority();
        MATCHVAL = 32'hFFFF_0000; DIVISOR = 16'd3; EN = 1'b1;
        LOAD = 1'b1; LOADVAL = 32'h100;
        step();
        LOAD = 1'b0;
        step(); step(); step();  // prescaler now at 3: increment due next edge
        chk_cnt++; if (Count !== 32'h100) $display("FAIL prio_setup: got %h want %h", Count, 32'h100); else pass_cnt++;
        TESTCOUNT = 1'b1; RTCTCOUNT = 32'd5; LOAD = 1'b1; LOADVAL = 32'd9;
        step();
        TESTCOUNT = 1'b0; LOAD = 1'b0;
        chk_cnt++; if (Count !== 32'd5) $display("FAIL prio_test: got %h want 5", Count); else pass_cnt++;
        chk_cnt++; if (TICK !== 1'b0) $display("FAIL prio_test_tick: got %b want 0", TICK); else pass_cnt++;
        // Prescaler was held at 3, so the very next enabled edge increments.
        step();
        chk_cnt++; if (Count !== 32'd6) $display("FAIL prio_held_pre: got %h want 6", Count); else pass_cnt++;
        chk_cnt++; if (TICK !== 1'b1) $display("FAIL prio_held_tick: got %b want 1", TICK); else pass_cnt++;
        step(); step();          // prescaler at 2
        LOAD = 1'b1; LOADVAL = 32'd9;
        step();
        LOAD = 1'b0;
        chk_cnt++; if (Count !== 32'd9) $display("FAIL prio_load: got %h want 9", Count); else pass_cnt++;
        step(); step(); step();
        chk_cnt++; if (Count !== 32'd9) $display("FAIL prio_pre_clr: got %h want 9", Count); else pass_cnt++;
        step();
        chk_cnt++; if (Count !== 32'd10) $display("FAIL prio_after_load: got %h want 10", Count); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        DIVISOR = 16'd3; EN = 1'b1; MATCHVAL = 32'h1234;
        LOAD = 1'b1; LOADVAL = 32'h1234;
        step();
        LOAD = 1'b0;
        chk_cnt++; if (RAWINT !== 1'b1) $display("FAIL arst_pre_raw: got %b want 1", RAWINT); else pass_cnt++;
        step();                  // mid-period
        RTCRST = 1'b1;
        #1;
        chk_cnt++; if (Count !== 32'd1) $display("FAIL arst_count: got %h want 1", Count); else pass_cnt++;
        chk_cnt++; if (RAWINT !== 1'b0) $display("FAIL arst_rawint: got %b want 0", RAWINT); else pass_cnt++;
        chk_cnt++; if (WRAP !== 1'b0) $display("FAIL arst_wrap: got %b want 0", WRAP); else pass_cnt++;
        step();
        RTCRST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_cnt++;
            if (TICK !== (i == 4)) $display("FAIL arst_tick[%0d]: got %b want %b", i, TICK, (i == 4)); else pass_cnt++;
        end
        chk_cnt++; if (Count !== 32'd2) $display("FAIL arst_first_inc: got %h want 2", Count); else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_divide();
        test_wrap();
        test_match_mask();
        test_set_beats_clear();
        test_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_rtc_match_counter
`default_nettype wire
